// File: rtl/note_envelope.sv
// rtl/note_envelope.sv - ADSR gain envelope applied to a sample stream through a 2-cycle multiply pipeline
module note_envelope #(
  parameter logic [15:0] ATTACK_STEP   = 16'h0100,
  parameter logic [15:0] DECAY_STEP    = 16'h0040,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hA000,
  parameter logic [15:0] RELEASE_STEP  = 16'h0020
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        note_on,
  input  logic        note_off,
  input  logic [15:0] sample_in,
  input  logic        in_ready,
  output logic [15:0] sample_out,
  output logic        out_ready,
  output logic [15:0] env_level,
  output logic [2:0]  env_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [15:0]        s1, e1;
  logic               v1;
  logic [16:0]        att_sum, dec_diff, rel_diff;
  logic [15:0]        env_next;
  logic [2:0]         step_state, state_next;
  logic signed [32:0] s_ext, e_ext, product;
  logic               unused_product_bits;

  // The 17th bit catches both attack overflow and decay/release underflow.
  always_comb begin
    att_sum    = {1'b0, env_level} + {1'b0, ATTACK_STEP};
    dec_diff   = {1'b0, env_level} - {1'b0, DECAY_STEP};
    rel_diff   = {1'b0, env_level} - {1'b0, RELEASE_STEP};
    env_next   = env_level;
    step_state = env_state;
    case (env_state)
      ST_ATTACK: begin
        env_next = att_sum[16] ? 16'hFFFF : att_sum[15:0];
        if (att_sum[16] || att_sum[15:0] == 16'hFFFF) step_state = ST_DECAY;
      end
      ST_DECAY: begin
        if (dec_diff[16] || dec_diff[15:0] <= SUSTAIN_LEVEL) begin
          env_next   = SUSTAIN_LEVEL;
          step_state = ST_SUSTAIN;
        end else begin
          env_next = dec_diff[15:0];
        end
      end
      ST_SUSTAIN: env_next = SUSTAIN_LEVEL;
      ST_RELEASE: begin
        if (rel_diff[16] || rel_diff[15:0] == 16'h0000) begin
          env_next   = 16'h0000;
          step_state = ST_IDLE;
        end else begin
          env_next = rel_diff[15:0];
        end
      end
      default: begin
        env_next   = 16'h0000;
        step_state = ST_IDLE;
      end
    endcase

    // Gate events override whatever transition the gain step asked for.
    state_next = in_ready ? step_state : env_state;
    if (note_on)
      state_next = ST_ATTACK;
    else if (note_off && (env_state == ST_ATTACK || env_state == ST_DECAY ||
                          env_state == ST_SUSTAIN))
      state_next = ST_RELEASE;
  end

  always_comb begin
    s_ext   = {{17{s1[15]}}, s1};
    e_ext   = {17'b0, e1};
    product = s_ext * e_ext;
  end

  assign unused_product_bits = ^{product[32], product[15:0]};

  always_ff @(posedge clk_100) begin
    if (reset) begin
      env_state  <= ST_IDLE;
      env_level  <= 16'h0000;
      s1         <= 16'h0000;
      e1         <= 16'h0000;
      v1         <= 1'b0;
      sample_out <= 16'h0000;
      out_ready  <= 1'b0;
    end else begin
      env_state <= state_next;
      if (in_ready) env_level <= env_next;
      v1 <= in_ready;
      if (in_ready) begin
        s1 <= sample_in;
        e1 <= env_level;
      end
      out_ready <= v1;
      if (v1) sample_out <= product[31:16];
    end
  end

endmodule
